// File: rtl/uart_csr_pkg.sv
// Shared definitions for the UART CSR block: register byte offsets,
// bit positions inside CTRL / INT_* and the packed CFG field layout.
package uart_csr_pkg;

  localparam logic [4:0] OFF_TXDATA   = 5'h00;
  localparam logic [4:0] OFF_RXDATA   = 5'h04;
  localparam logic [4:0] OFF_CFG      = 5'h08;
  localparam logic [4:0] OFF_CTRL     = 5'h0C;
  localparam logic [4:0] OFF_STATUS   = 5'h10;
  localparam logic [4:0] OFF_INT_STAT = 5'h14;
  localparam logic [4:0] OFF_INT_EN   = 5'h18;
  localparam logic [4:0] OFF_BAUD     = 5'h1C;

  localparam int unsigned CTRL_TX_EN    = 0;
  localparam int unsigned CTRL_TX_FLUSH = 1;
  localparam int unsigned CTRL_RX_FLUSH = 2;

  localparam int unsigned INT_W        = 5;
  localparam int unsigned INT_TX_EMPTY = 0;
  localparam int unsigned INT_RX_AVAIL = 1;
  localparam int unsigned INT_RX_OVF   = 2;
  localparam int unsigned INT_TX_OVF   = 3;
  localparam int unsigned INT_PARITY   = 4;

  // Packed so that bit 0 is data_bit_num[0] and bit 4 is parity_type.
  typedef struct packed {
    logic       parity_type;
    logic       parity_en;
    logic       stop_bit_num;
    logic [1:0] data_bit_num;
  } cfg_t;

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO used for the UART TX and RX byte paths.
// Ports: push/din write an entry, pop retires the head (dout), flush empties
// the FIFO and discards any same-cycle push. empty/full/level report state.
// A push while full is accepted when a pop happens in the same cycle.
module uart_sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           dout,
  output logic                       empty,
  output logic                       full,
  output logic [$clog2(DEPTH+1)-1:0] level
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned LVL_W = $clog2(DEPTH + 1);

  logic [PTR_W-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop, mem_we;

  assign empty = (level_q == '0);
  assign full  = (level_q == LVL_W'(DEPTH));
  assign level = level_q;
  assign dout  = mem_q[rptr_q];

  always_comb begin
    do_pop  = pop & ~empty;
    do_push = push & (~full | do_pop);
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    level_d = level_q;
    mem_we  = 1'b0;
    if (flush) begin
      wptr_d  = '0;
      rptr_d  = '0;
      level_d = '0;
    end else begin
      mem_we = do_push;
      if (do_push) wptr_d = wptr_q + PTR_W'(1);
      if (do_pop)  rptr_d = rptr_q + PTR_W'(1);
      if (do_push && !do_pop)      level_d = level_q + LVL_W'(1);
      else if (!do_push && do_pop) level_d = level_q - LVL_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      level_q <= level_d;
    end
  end

  // Storage needs no reset: entries are only visible through level/pointers.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[wptr_q] <= din;
  end

endmodule

// File: rtl/uart_csr_fifo.sv
// UART control/status register block with TX and RX byte FIFOs.
// Bus side: waddr/wdata/wr_en and raddr/rd_en with registered rdata and
// one-cycle wack/rack (+ address error flags). UART side: tx_data/tx_valid/
// tx_ready toward the transmitter, rx_data/rx_valid/parity_error from the
// receiver. Line config (data_bit_num, stop_bit_num, parity_*), baud_div and
// a registered, maskable irq are driven from the CSRs.
module uart_csr_fifo
  import uart_csr_pkg::*;
#(
  parameter int unsigned ADDR_W   = 12,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned TX_DEPTH = 8,
  parameter int unsigned RX_DEPTH = 8,
  parameter logic [15:0] DIV_RST  = 16'd54
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [ADDR_W-1:0] raddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              wr_en,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rdata,
  output logic              wack,
  output logic              rack,
  output logic              waddrerr,
  output logic              raddrerr,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  input  logic              parity_error,
  output logic [1:0]        data_bit_num,
  output logic              stop_bit_num,
  output logic              parity_en,
  output logic              parity_type,
  output logic [15:0]       baud_div,
  output logic              irq
);

  localparam int unsigned TXL_W = $clog2(TX_DEPTH + 1);
  localparam int unsigned RXL_W = $clog2(RX_DEPTH + 1);

  cfg_t              cfg_q, cfg_d;
  logic              tx_en_q, tx_en_d;
  logic [INT_W-1:0]  int_stat_q, int_stat_d, int_en_q, int_en_d, int_set;
  logic [15:0]       baud_q, baud_d;
  logic [DATA_W-1:0] rdata_q, rdata_d, rval;
  logic              wack_q, wack_d, rack_q, rack_d;
  logic              waddrerr_q, waddrerr_d, raddrerr_q, raddrerr_d;
  logic              irq_q, irq_d;
  logic [TXL_W-1:0]  tx_lvl_prev_q, tx_lvl_prev_d, tx_level;
  logic [RXL_W-1:0]  rx_level;
  logic              waddr_ok, raddr_ok;
  logic              tx_push, tx_pop, tx_flush, tx_empty, tx_full;
  logic              rx_pop, rx_flush, rx_empty, rx_full;
  logic [7:0]        rx_dout;
  logic              unused_wdata;

  assign unused_wdata = ^wdata;

  // Every aligned offset 0x00..0x1C is a register; anything else is an error.
  assign waddr_ok = (waddr[ADDR_W-1:5] == '0) && (waddr[1:0] == 2'b00);
  assign raddr_ok = (raddr[ADDR_W-1:5] == '0) && (raddr[1:0] == 2'b00);

  assign tx_push  = wr_en & waddr_ok & (waddr[4:0] == OFF_TXDATA);
  assign tx_flush = wr_en & waddr_ok & (waddr[4:0] == OFF_CTRL) & wdata[CTRL_TX_FLUSH];
  assign rx_flush = wr_en & waddr_ok & (waddr[4:0] == OFF_CTRL) & wdata[CTRL_RX_FLUSH];
  assign rx_pop   = rd_en & raddr_ok & (raddr[4:0] == OFF_RXDATA) & ~rx_empty;
  assign tx_valid = tx_en_q & ~tx_empty;
  assign tx_pop   = tx_valid & tx_ready;

  uart_sync_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk(clk), .rst_n(rst_n), .push(tx_push), .pop(tx_pop), .flush(tx_flush),
    .din(wdata[7:0]), .dout(tx_data), .empty(tx_empty), .full(tx_full),
    .level(tx_level)
  );

  uart_sync_fifo #(.WIDTH(8), .DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk(clk), .rst_n(rst_n), .push(rx_valid), .pop(rx_pop), .flush(rx_flush),
    .din(rx_data), .dout(rx_dout), .empty(rx_empty), .full(rx_full),
    .level(rx_level)
  );

  always_comb begin
    cfg_d         = cfg_q;
    tx_en_d       = tx_en_q;
    int_en_d      = int_en_q;
    baud_d        = baud_q;
    tx_lvl_prev_d = tx_level;
    wack_d        = wr_en;
    waddrerr_d    = wr_en & ~waddr_ok;
    rack_d        = rd_en;
    raddrerr_d    = rd_en & ~raddr_ok;
    irq_d         = |(int_stat_q & int_en_q);

    if (wr_en && waddr_ok) begin
      case (waddr[4:0])
        OFF_CFG:    cfg_d    = cfg_t'(wdata[4:0]);
        OFF_CTRL:   tx_en_d  = wdata[CTRL_TX_EN];
        OFF_INT_EN: int_en_d = wdata[INT_W-1:0];
        OFF_BAUD:   baud_d   = wdata[15:0];
        default:    ;
      endcase
    end

    // Overflow means the byte was really lost: no freeing pop, no flush.
    int_set               = '0;
    int_set[INT_TX_EMPTY] = (tx_lvl_prev_q == TXL_W'(1)) && (tx_level == '0);
    int_set[INT_RX_AVAIL] = ~rx_empty;
    int_set[INT_RX_OVF]   = rx_valid & rx_full & ~rx_pop & ~rx_flush;
    int_set[INT_TX_OVF]   = tx_push & tx_full & ~tx_pop & ~tx_flush;
    int_set[INT_PARITY]   = parity_error;

    int_stat_d = int_stat_q;
    if (wr_en && waddr_ok && (waddr[4:0] == OFF_INT_STAT))
      int_stat_d = int_stat_q & ~wdata[INT_W-1:0];
    int_stat_d = int_stat_d | int_set;

    rval = '0;
    case (raddr[4:0])
      OFF_RXDATA:   if (!rx_empty) rval[7:0] = rx_dout;
      OFF_CFG:      rval[4:0] = cfg_q;
      OFF_CTRL:     rval[0] = tx_en_q;
      OFF_STATUS: begin
        rval[0]     = tx_empty;
        rval[1]     = tx_full;
        rval[2]     = rx_empty;
        rval[3]     = rx_full;
        rval[11:8]  = 4'(tx_level);
        rval[15:12] = 4'(rx_level);
      end
      OFF_INT_STAT: rval[INT_W-1:0] = int_stat_q;
      OFF_INT_EN:   rval[INT_W-1:0] = int_en_q;
      OFF_BAUD:     rval[15:0] = baud_q;
      default:      ;
    endcase

    rdata_d = rdata_q;
    if (rd_en) rdata_d = raddr_ok ? rval : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg_q         <= '0;
      tx_en_q       <= 1'b0;
      int_stat_q    <= '0;
      int_en_q      <= '0;
      baud_q        <= DIV_RST;
      rdata_q       <= '0;
      wack_q        <= 1'b0;
      rack_q        <= 1'b0;
      waddrerr_q    <= 1'b0;
      raddrerr_q    <= 1'b0;
      irq_q         <= 1'b0;
      tx_lvl_prev_q <= '0;
    end else begin
      cfg_q         <= cfg_d;
      tx_en_q       <= tx_en_d;
      int_stat_q    <= int_stat_d;
      int_en_q      <= int_en_d;
      baud_q        <= baud_d;
      rdata_q       <= rdata_d;
      wack_q        <= wack_d;
      rack_q        <= rack_d;
      waddrerr_q    <= waddrerr_d;
      raddrerr_q    <= raddrerr_d;
      irq_q         <= irq_d;
      tx_lvl_prev_q <= tx_lvl_prev_d;
    end
  end

  assign rdata        = rdata_q;
  assign wack         = wack_q;
  assign rack         = rack_q;
  assign waddrerr     = waddrerr_q;
  assign raddrerr     = raddrerr_q;
  assign irq          = irq_q;
  assign baud_div     = baud_q;
  assign data_bit_num = cfg_q.data_bit_num;
  assign stop_bit_num = cfg_q.stop_bit_num;
  assign parity_en    = cfg_q.parity_en;
  assign parity_type  = cfg_q.parity_type;

endmodule

// File: tb/tb_uart_csr_fifo.sv
// Directed bench for uart_csr_fifo: register access, TX/RX FIFO behaviour,
// interrupt set/clear priority, address errors and reset mid-access.
module tb_uart_csr_fifo;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [11:0] waddr, raddr;
  logic [31:0] wdata, rdata;
  logic        wr_en, rd_en, wack, rack, waddrerr, raddrerr;
  logic [7:0]  tx_data, rx_data;
  logic        tx_valid, tx_ready, rx_valid, parity_error;
  logic [1:0]  data_bit_num;
  logic        stop_bit_num, parity_en, parity_type, irq;
  logic [15:0] baud_div;
  logic [31:0] rd_val;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  uart_csr_fifo #(
    .ADDR_W(12), .DATA_W(32), .TX_DEPTH(8), .RX_DEPTH(8), .DIV_RST(16'd54)
  ) dut (
    .clk(clk), .rst_n(rst_n), .waddr(waddr), .raddr(raddr), .wdata(wdata),
    .wr_en(wr_en), .rd_en(rd_en), .rdata(rdata), .wack(wack), .rack(rack),
    .waddrerr(waddrerr), .raddrerr(raddrerr), .tx_data(tx_data),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .rx_data(rx_data),
    .rx_valid(rx_valid), .parity_error(parity_error),
    .data_bit_num(data_bit_num), .stop_bit_num(stop_bit_num),
    .parity_en(parity_en), .parity_type(parity_type), .baud_div(baud_div),
    .irq(irq)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic bus_wr(input logic [11:0] a, input logic [31:0] d, input logic exp_err);
    @(negedge clk);
    waddr = a; wdata = d; wr_en = 1'b1;
    @(posedge clk); #1;
    wr_en = 1'b0;
    check("wack", {31'b0, wack}, 32'd1);
    check("waddrerr", {31'b0, waddrerr}, {31'b0, exp_err});
  endtask

  task automatic bus_rd(input string tag, input logic [11:0] a, input logic [31:0] exp,
                        input logic exp_err);
    @(negedge clk);
    raddr = a; rd_en = 1'b1;
    @(posedge clk); #1;
    rd_en = 1'b0;
    check({tag, "_rack"}, {31'b0, rack}, 32'd1);
    check({tag, "_raddrerr"}, {31'b0, raddrerr}, {31'b0, exp_err});
    check(tag, rdata, exp);
  endtask

  task automatic rx_push(input logic [7:0] b);
    @(negedge clk);
    rx_data = b; rx_valid = 1'b1;
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; waddr = '0; raddr = '0; wdata = '0; wr_en = 1'b0; rd_en = 1'b0;
    tx_ready = 1'b0; rx_data = '0; rx_valid = 1'b0; parity_error = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Reset state
    check("rst_irq", {31'b0, irq}, 32'd0);
    check("rst_wack", {31'b0, wack}, 32'd0);
    check("rst_rack", {31'b0, rack}, 32'd0);
    check("rst_tx_valid", {31'b0, tx_valid}, 32'd0);
    check("rst_baud_div", {16'b0, baud_div}, 32'd54);
    check("rst_rdata", rdata, 32'd0);
    bus_rd("rst_baud", 12'h01C, 32'h36, 1'b0);
    bus_rd("rst_status", 12'h010, 32'h0005, 1'b0);

    // CFG write/read and config outputs
    bus_wr(12'h008, 32'h1B, 1'b0);
    check("cfg_data_bits", {30'b0, data_bit_num}, 32'd3);
    check("cfg_stop", {31'b0, stop_bit_num}, 32'd0);
    check("cfg_par_en", {31'b0, parity_en}, 32'd1);
    check("cfg_par_type", {31'b0, parity_type}, 32'd1);
    @(posedge clk); #1;
    check("wack_one_cycle", {31'b0, wack}, 32'd0);
    bus_rd("cfg_rd", 12'h008, 32'h1B, 1'b0);
    @(posedge clk); #1;
    check("rack_one_cycle", {31'b0, rack}, 32'd0);
    check("rdata_hold", rdata, 32'h1B);

    // TX: 9 pushes with tx_en=0 into an 8-deep FIFO
    for (int i = 0; i < 9; i++) bus_wr(12'h000, 32'h10 + 32'(i), 1'b0);
    check("tx_valid_disabled", {31'b0, tx_valid}, 32'd0);
    check("tx_head", {24'b0, tx_data}, 32'h10);
    bus_rd("tx_full_status", 12'h010, 32'h0806, 1'b0);
    bus_rd("tx_ovf_int", 12'h014, 32'h08, 1'b0);
    tx_ready = 1'b1;
    bus_wr(12'h00C, 32'h1, 1'b0);
    for (int i = 0; i < 8; i++) begin
      check("tx_valid_drain", {31'b0, tx_valid}, 32'd1);
      check("tx_data_order", {24'b0, tx_data}, 32'h10 + 32'(i));
      @(posedge clk); #1;
    end
    check("tx_valid_empty", {31'b0, tx_valid}, 32'd0);
    tx_ready = 1'b0;
    @(posedge clk); #1;
    bus_rd("tx_empty_evt", 12'h014, 32'h09, 1'b0);
    bus_wr(12'h014, 32'h1F, 1'b0);
    bus_rd("int_w1c", 12'h014, 32'h00, 1'b0);

    // RX: single byte, interrupt, pop and empty read
    bus_wr(12'h018, 32'h02, 1'b0);
    rx_push(8'hA5);
    check("rx_irq_lag", {31'b0, irq}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    check("rx_irq", {31'b0, irq}, 32'd1);
    bus_rd("rx_pop", 12'h004, 32'hA5, 1'b0);
    bus_rd("rx_empty_rd", 12'h004, 32'h00, 1'b0);
    bus_rd("rx_status", 12'h010, 32'h0005, 1'b0);
    bus_wr(12'h014, 32'h02, 1'b0);
    @(posedge clk); #1;
    check("irq_cleared", {31'b0, irq}, 32'd0);

    // RX overflow and set-over-clear priority
    for (int i = 0; i < 9; i++) rx_push(8'h30 + 8'(i));
    bus_rd("rx_ovf_int", 12'h014, 32'h06, 1'b0);
    bus_wr(12'h014, 32'h04, 1'b0);
    bus_rd("ovf_cleared", 12'h014, 32'h02, 1'b0);
    @(negedge clk);
    rx_data = 8'hEE; rx_valid = 1'b1; waddr = 12'h014; wdata = 32'h04; wr_en = 1'b1;
    @(posedge clk); #1;
    rx_valid = 1'b0; wr_en = 1'b0;
    check("prio_wack", {31'b0, wack}, 32'd1);
    bus_rd("set_over_clear", 12'h014, 32'h06, 1'b0);
    @(negedge clk); parity_error = 1'b1;
    @(posedge clk); #1; parity_error = 1'b0;
    bus_rd("parity_int", 12'h014, 32'h16, 1'b0);
    bus_rd("rx_full_status", 12'h010, 32'h8009, 1'b0);
    bus_rd("rx_first", 12'h004, 32'h30, 1'b0);
    bus_rd("rx_lvl7_status", 12'h010, 32'h7001, 1'b0);
    bus_wr(12'h00C, 32'h05, 1'b0);
    bus_rd("flush_status", 12'h010, 32'h0005, 1'b0);
    bus_rd("ctrl_rd", 12'h00C, 32'h01, 1'b0);

    // Bad write concurrent with a good read
    @(negedge clk);
    waddr = 12'h020; wdata = 32'hFFFF_FFFF; wr_en = 1'b1;
    raddr = 12'h010; rd_en = 1'b1;
    @(posedge clk); #1;
    wr_en = 1'b0; rd_en = 1'b0;
    check("bad_wack", {31'b0, wack}, 32'd1);
    check("bad_waddrerr", {31'b0, waddrerr}, 32'd1);
    check("conc_rack", {31'b0, rack}, 32'd1);
    check("conc_raddrerr", {31'b0, raddrerr}, 32'd0);
    check("conc_status", rdata, 32'h0005);
    bus_rd("bad_wr_baud", 12'h01C, 32'h36, 1'b0);
    bus_rd("bad_wr_cfg", 12'h008, 32'h1B, 1'b0);
    bus_rd("misaligned_rd", 12'h00A, 32'h0, 1'b1);
    bus_rd("high_rd", 12'h108, 32'h0, 1'b1);

    // Asynchronous reset while a write is pending
    @(negedge clk);
    waddr = 12'h008; wdata = 32'h07; wr_en = 1'b1;
    #2 rst_n = 1'b0;
    @(posedge clk); #1;
    wr_en = 1'b0;
    check("rst_mid_wack", {31'b0, wack}, 32'd0);
    check("rst_mid_cfg", {30'b0, data_bit_num}, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_mid_wack2", {31'b0, wack}, 32'd0);
    bus_rd("rst_mid_cfg_rd", 12'h008, 32'h0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_csr_fifo.md
# uart_csr_fifo

Parametrised UART control/status register block with buffered TX and RX data paths. It sits between the bus-side register access port and the UART transmitter/receiver cores. It decodes word-aligned register accesses, holds line configuration and baud divisor, and buffers bytes in a TX FIFO and an RX FIFO. It also raises a maskable, write-1-to-clear interrupt.

## Interface
- ADDR_W, 12, register address width
- DATA_W, 32, bus data width (≥ 16)
- TX_DEPTH, 8, TX FIFO entries (power of 2, ≥ 2)
- RX_DEPTH, 8, RX FIFO entries (power of 2, ≥ 2)
- DIV_RST, 16'd54, reset value of baud divisor
- clk  in  1  clock; single clock domain
- rst_n  in  1  asynchronous, active-low reset
- waddr / raddr  in  ADDR_W  write / read byte address
- wdata  in  DATA_W  write data
- wr_en / rd_en  in  1  write / read request, one access per asserted cycle
- rdata  out  DATA_W  registered read data
- wack / rack  out  1  one-cycle write / read acknowledge
- waddrerr / raddrerr  out  1  address error, valid with wack / rack
- tx_data  out  8  head of TX FIFO
- tx_valid  out  1  TX byte available, equal to tx_en & !tx_empty
- tx_ready  in  1  transmitter accepts byte; pops when tx_valid & tx_ready
- rx_data  in  8  received byte
- rx_valid  in  1  push rx_data into RX FIFO
- parity_error  in  1  pulse from receiver
- data_bit_num  out  2  CFG[1:0]
- stop_bit_num, parity_en, parity_type  out  1 each  CFG[2], CFG[3], CFG[4]
- baud_div  out  16  BAUD register
- irq  out  1  registered, equal to |(INT_STAT & INT_EN)

## Operation
- Register map, with all other addresses reported as errors:
  - 0x00 TXDATA (W: push wdata[7:0]; R: 0)
  - 0x04 RXDATA (R: pop, {0,byte})
  - 0x08 CFG (RW [4:0])
  - 0x0C CTRL ([0] tx_en RW; [1] tx_flush and [2] rx_flush, write-1 self-clearing, read 0)
  - 0x10 STATUS (RO: [0] tx_empty, [1] tx_full, [2] rx_empty, [3] rx_full, [11:8] tx_level, [15:12] rx_level)
  - 0x14 INT_STAT (W1C: [0] tx_empty_evt, [1] rx_avail, [2] rx_overflow, [3] tx_overflow, [4] parity_err)
  - 0x18 INT_EN (RW [4:0])
  - 0x1C BAUD (RW [15:0])
- Reset values:
  - All registers and FIFOs are cleared; BAUD resets to DIV_RST.
  - Outputs reset to: rdata 0, wack/rack/waddrerr/raddrerr 0, tx_valid 0, irq 0, config outputs 0, baud_div DIV_RST.
- wr_en and rd_en in the same cycle are both served, including to different registers.
- Write to a bad address: no state change, wack=1, waddrerr=1.
- Read from a bad address: rdata=0, rack=1, raddrerr=1.
- TX push when full: byte dropped, tx_overflow set.
- TX push and pop in the same cycle: both take effect, level unchanged, including when full.
- RX push when full: byte dropped, rx_overflow set.
- RX push and pop in the same cycle: both take effect, level unchanged.
- RXDATA read when empty: rdata=0, no pop, no error.
- Flush: the FIFO is emptied at the write edge. A same-cycle push to that FIFO is discarded.
- INT_STAT event sources:
  - tx_empty_evt sets on the TX level transition 1→0.
  - rx_avail sets while rx_level ≠ 0.
  - parity_err sets on a parity_error pulse.
- INT_STAT set has priority over a same-cycle W1C clear.
- Levels are $clog2(DEPTH+1) bits wide, zero-extended into their STATUS fields. Pointers wrap modulo DEPTH.

## Timing
- Write accepted at edge N; register and outputs update at N. wack/waddrerr are high during cycle N+1 for exactly one cycle per wr_en cycle.
- Read sampled at edge N; rdata and rack/raddrerr are valid in cycle N+1. rdata holds until the next read.
- RX pop occurs at edge N, so the next read observes the new head.
- tx_data/tx_valid are combinational from FIFO state. A byte pushed at edge N is visible in cycle N+1.
- irq lags INT_STAT/INT_EN by one cycle.
- Asynchronous reset mid-transfer: FIFOs are emptied, pending acks are dropped, and no acknowledge is issued for the interrupted access.

## Structure
- Package uart_csr_pkg holds:
  - register offset localparams
  - CFG/CTRL/INT bit indices
  - a typedef struct for CFG fields
- Sub-module uart_sync_fifo (params WIDTH, DEPTH), instantiated twice with:
  - push, pop, flush inputs
  - dout, empty, full, level outputs
  - simultaneous push/pop allowed when full
- The top level contains decode, CSRs, the INT logic and the read mux.

## Test plan
- Reset → BAUD reads 0x36, STATUS reads 0x0005, irq=0, all acks 0.
- Write CFG=0x1B, then read → rdata=0x1B, data_bit_num=3, parity_en=1, parity_type=1; wack then rack each one cycle.
- Push 9 bytes with tx_en=0 and TX_DEPTH=8 → tx_full=1, INT_STAT[3]=1. Then set tx_en, tx_ready=1 → 8 bytes out in order, tx_empty_evt set.
- Push 0xA5 on rx_valid with INT_EN=0x02 → irq=1. Read RXDATA → 0xA5. Second read → 0, no pop.
- Write INT_STAT=0x04 in the same cycle as an RX overflow → bit 2 remains set.
- wr_en to 0x20 with concurrent rd_en to 0x10 → waddrerr=1, rack with valid STATUS, no state change.
